// File: rtl/fetch_prefetch_queue_if.sv
// fetch_prefetch_queue_if: memory read port, issue handshake and redirect bundle of the prefetch queue
interface fetch_prefetch_queue_if #(parameter int DEPTH = 4);
  logic [31:0] mem_raddr;
  logic mem_ren;
  logic [31:0] mem_rdata;
  logic deq_valid;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc;
  logic deq_ready;
  logic redirect;
  logic [31:0] redirect_pc;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output mem_raddr, mem_ren, deq_valid, deq_instr, deq_pc, count,
    input mem_rdata, deq_ready, redirect, redirect_pc
  );
  modport slave (
    input mem_raddr, mem_ren, deq_valid, deq_instr, deq_pc, count,
    output mem_rdata, deq_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential instruction prefetch FIFO with issue handshake and redirect flush
module fetch_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic clk,
  input logic rst,
  fetch_prefetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW + 1)'(1);
  logic [31:0] fetch_pc;
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic push, pop;
  assign push = bus.mem_ren;
  assign pop = bus.deq_valid && bus.deq_ready && !bus.redirect;
  assign bus.mem_raddr = fetch_pc;
  assign bus.mem_ren = (count != FULL) && !bus.redirect;
  assign bus.deq_valid = count != '0;
  assign bus.deq_instr = bus.deq_valid ? instr_mem[rd_ptr] : 32'h0;
  assign bus.deq_pc = bus.deq_valid ? pc_mem[rd_ptr] : 32'h0;
  assign bus.count = count;
  always_ff @(posedge clk)
    if (push) begin
      instr_mem[wr_ptr] <= bus.mem_rdata;
      pc_mem[wr_ptr] <= fetch_pc;
    end
  // redirect wins over push and pop: the head shown this cycle is dropped
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        fetch_pc <= fetch_pc + 32'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= (push && !pop) ? count + ONE : (pop && !push) ? count - ONE : count;
    end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: randomized and directed checks of the prefetch queue against a queue-based model
module tb_fetch_prefetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] seed = 32'h0;
  int errors = 0;
  int checks = 0;
  logic [31:0] q_pc[$];
  logic [31:0] q_in[$];
  logic [31:0] m_fpc = RESET_PC;
  fetch_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();
  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rdata = (bus.mem_raddr + 32'd100) ^ seed;
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a + 32'd100) ^ seed;
  endfunction
  function automatic logic e_valid();
    return q_pc.size() != 0;
  endfunction
  function automatic logic [31:0] e_pc();
    return q_pc.size() != 0 ? q_pc[0] : 32'h0;
  endfunction
  function automatic logic [31:0] e_in();
    return q_in.size() != 0 ? q_in[0] : 32'h0;
  endfunction
  function automatic int e_cnt();
    return q_pc.size();
  endfunction
  function automatic logic e_ren();
    return q_pc.size() != DEPTH && !bus.redirect;
  endfunction
  task automatic drive(input logic r, input logic j, input logic [31:0] jpc);
    bus.deq_ready = r;
    bus.redirect = j;
    bus.redirect_pc = jpc;
    #1;
  endtask
  task automatic advance();
    if (bus.redirect) begin
      q_pc.delete();
      q_in.delete();
      m_fpc = bus.redirect_pc;
    end else begin
      bit ren;
      ren = q_pc.size() < DEPTH;
      if (q_pc.size() != 0 && bus.deq_ready) begin
        void'(q_pc.pop_front());
        void'(q_in.pop_front());
      end
      if (ren) begin
        q_pc.push_back(m_fpc);
        q_in.push_back(word(m_fpc));
        m_fpc = m_fpc + 32'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    drive(1'b1, 1'b0, 32'h0);
    checks++; if (bus.deq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.deq_valid); end
    checks++; if (bus.deq_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", bus.deq_instr); end
    checks++; if (bus.deq_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", bus.deq_pc); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.mem_raddr !== RESET_PC) begin errors++; $display("FAIL reset_raddr: got %h want %h", bus.mem_raddr, RESET_PC); end
    checks++; if (bus.mem_ren !== 1'b1) begin errors++; $display("FAIL reset_ren: got %b want 1", bus.mem_ren); end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask
  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      checks++; if (bus.deq_valid !== e_valid()) begin errors++; $display("FAIL stream_valid[%0d]: got %b want %b", i, bus.deq_valid, e_valid()); end
      checks++; if (bus.deq_pc !== e_pc()) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, bus.deq_pc, e_pc()); end
      checks++; if (bus.deq_instr !== e_in()) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, bus.deq_instr, e_in()); end
      checks++; if (int'(bus.count) != e_cnt()) begin errors++; $display("FAIL stream_count[%0d]: got %0d want %0d", i, bus.count, e_cnt()); end
      advance();
    end
  endtask
  task automatic test_stall();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      checks++; if (int'(bus.count) != e_cnt()) begin errors++; $display("FAIL stall_count[%0d]: got %0d want %0d", i, bus.count, e_cnt()); end
      checks++; if (bus.mem_ren !== e_ren()) begin errors++; $display("FAIL stall_ren[%0d]: got %b want %b", i, bus.mem_ren, e_ren()); end
      checks++; if (bus.mem_raddr !== m_fpc) begin errors++; $display("FAIL stall_raddr[%0d]: got %h want %h", i, bus.mem_raddr, m_fpc); end
      advance();
    end
    drive(1'b1, 1'b0, 32'h0);
    checks++; if (bus.count !== 3'd4 || bus.mem_ren !== 1'b0) begin errors++; $display("FAIL stall_full: got count=%0d ren=%b want count=4 ren=0", bus.count, bus.mem_ren); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      checks++; if (bus.deq_valid !== e_valid()) begin errors++; $display("FAIL drain_valid[%0d]: got %b want %b", i, bus.deq_valid, e_valid()); end
      checks++; if (bus.deq_pc !== e_pc()) begin errors++; $display("FAIL drain_pc[%0d]: got %h want %h", i, bus.deq_pc, e_pc()); end
      checks++; if (bus.deq_instr !== e_in()) begin errors++; $display("FAIL drain_instr[%0d]: got %h want %h", i, bus.deq_instr, e_in()); end
      advance();
    end
  endtask
  task automatic test_redirect();
    drive(1'b1, 1'b1, 32'h100);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      advance();
    end
    drive(1'b1, 1'b1, 32'h40);
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL redir_precount: got %0d want 3", bus.count); end
    checks++; if (bus.mem_ren !== 1'b0) begin errors++; $display("FAIL redir_ren: got %b want 0", bus.mem_ren); end
    advance();
    drive(1'b1, 1'b0, 32'h0);
    checks++; if (bus.count !== 3'd0 || bus.deq_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got count=%0d valid=%b want 0 0", bus.count, bus.deq_valid); end
    checks++; if (bus.mem_raddr !== 32'h40) begin errors++; $display("FAIL redir_raddr: got %h want 00000040", bus.mem_raddr); end
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      checks++; if (bus.deq_valid !== 1'b1 || bus.deq_pc !== 32'h40 + 32'(i)) begin errors++; $display("FAIL redir_pc[%0d]: got valid=%b pc=%h want 1 %h", i, bus.deq_valid, bus.deq_pc, 32'h40 + 32'(i)); end
      checks++; if (bus.deq_instr !== e_in()) begin errors++; $display("FAIL redir_instr[%0d]: got %h want %h", i, bus.deq_instr, e_in()); end
      advance();
    end
  endtask
  task automatic test_redirect_full();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      advance();
    end
    drive(1'b1, 1'b1, 32'h200);
    checks++; if (bus.count !== 3'd4 || bus.deq_valid !== 1'b1) begin errors++; $display("FAIL rfull_pre: got count=%0d valid=%b want 4 1", bus.count, bus.deq_valid); end
    checks++; if (bus.mem_ren !== 1'b0) begin errors++; $display("FAIL rfull_ren: got %b want 0", bus.mem_ren); end
    advance();
    drive(1'b1, 1'b0, 32'h0);
    checks++; if (bus.count !== 3'd0 || bus.deq_valid !== 1'b0 || bus.mem_raddr !== 32'h200) begin errors++; $display("FAIL rfull_flush: got count=%0d valid=%b raddr=%h want 0 0 00000200", bus.count, bus.deq_valid, bus.mem_raddr); end
    advance();
    drive(1'b1, 1'b0, 32'h0);
    checks++; if (bus.deq_pc !== 32'h200 || bus.deq_instr !== word(32'h200)) begin errors++; $display("FAIL rfull_head: got pc=%h instr=%h want 00000200 %h", bus.deq_pc, bus.deq_instr, word(32'h200)); end
    advance();
  endtask
  task automatic test_wrap();
    logic [31:0] want [4];
    want[0] = 32'hFFFFFFFE;
    want[1] = 32'hFFFFFFFF;
    want[2] = 32'h0;
    want[3] = 32'h1;
    drive(1'b1, 1'b1, 32'hFFFFFFFE);
    advance();
    drive(1'b1, 1'b0, 32'h0);
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      checks++; if (bus.deq_pc !== want[i] || bus.deq_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, bus.deq_pc, want[i]); end
      checks++; if (bus.deq_instr !== word(want[i])) begin errors++; $display("FAIL wrap_instr[%0d]: got %h want %h", i, bus.deq_instr, word(want[i])); end
      advance();
    end
  endtask
  task automatic test_random();
    seed = $urandom;
    drive(1'b1, 1'b1, $urandom);
    advance();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0), $urandom);
      checks++; if (bus.deq_valid !== e_valid()) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, bus.deq_valid, e_valid()); end
      checks++; if (bus.deq_pc !== e_pc()) begin errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, bus.deq_pc, e_pc()); end
      checks++; if (bus.deq_instr !== e_in()) begin errors++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, bus.deq_instr, e_in()); end
      checks++; if (int'(bus.count) != e_cnt()) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, bus.count, e_cnt()); end
      checks++; if (bus.mem_ren !== e_ren()) begin errors++; $display("FAIL rnd_ren[%0d]: got %b want %b", i, bus.mem_ren, e_ren()); end
      checks++; if (bus.mem_raddr !== m_fpc) begin errors++; $display("FAIL rnd_raddr[%0d]: got %h want %h", i, bus.mem_raddr, m_fpc); end
      advance();
    end
  endtask
  task automatic test_async_reset();
    drive(1'b0, 1'b1, 32'h300);
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      advance();
    end
    drive(1'b0, 1'b0, 32'h0);
    checks++; if (bus.count !== 3'd2 || bus.deq_pc !== 32'h300) begin errors++; $display("FAIL arst_pre: got count=%0d pc=%h want 2 00000300", bus.count, bus.deq_pc); end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.count !== 3'd0 || bus.deq_valid !== 1'b0) begin errors++; $display("FAIL arst_state: got count=%0d valid=%b want 0 0", bus.count, bus.deq_valid); end
    checks++; if (bus.deq_pc !== 32'h0 || bus.deq_instr !== 32'h0) begin errors++; $display("FAIL arst_head: got pc=%h instr=%h want 0 0", bus.deq_pc, bus.deq_instr); end
    checks++; if (bus.mem_raddr !== RESET_PC || bus.mem_ren !== 1'b1) begin errors++; $display("FAIL arst_fetch: got raddr=%h ren=%b want %h 1", bus.mem_raddr, bus.mem_ren, RESET_PC); end
    q_pc.delete();
    q_in.delete();
    m_fpc = RESET_PC;
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      checks++; if (bus.deq_valid !== 1'b1 || bus.deq_pc !== RESET_PC + 32'(i)) begin errors++; $display("FAIL arst_restart[%0d]: got valid=%b pc=%h want 1 %h", i, bus.deq_valid, bus.deq_pc, RESET_PC + 32'(i)); end
      advance();
    end
  endtask
  initial begin
    bus.deq_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    #2;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_full();
    test_wrap();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Instruction prefetch buffer between main-memory read port 0 and the issue register. It generates sequential fetch addresses and captures instruction words from the combinational memory read port. Words are held in a small FIFO together with their PCs and presented to the issue stage through a valid/ready handshake. The issue stage can stall by withholding ready, and a jump can redirect fetch, which flushes all prefetched words.

## Interface
- DEPTH, 4: number of FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0: first fetch address after reset.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_raddr  out  32  fetch address to main-memory read port 0.
- mem_ren  out  1  fetch strobe; mem_rdata is captured on the edge where this is 1.
- mem_rdata  in  32  instruction word; combinational function of mem_raddr in the same cycle.
- deq_valid  out  1  head entry is valid.
- deq_instr  out  32  head instruction word; 32'h0 (NOP) when empty.
- deq_pc  out  32  PC of the head instruction; 0 when empty.
- deq_ready  in  1  issue stage accepts the head this cycle (it is low when the issue stage stalls).
- redirect  in  1  jump taken; flush the queue and restart fetch.
- redirect_pc  in  32  new fetch address, used when redirect=1.
- count  out  clog2(DEPTH)+1  current occupancy.

## Operation
- State:
  - fetch_pc (32 bits).
  - Storage arrays instr_mem[DEPTH] and pc_mem[DEPTH].
  - Read and write pointers of clog2(DEPTH) bits each; both wrap modulo DEPTH.
  - count.
- Outputs:
  - mem_raddr = fetch_pc.
  - mem_ren = (count != DEPTH) && !redirect.
  - deq_valid = (count != 0).
  - deq_instr and deq_pc come from the read pointer when deq_valid=1, and are 0 otherwise.
- Push, when mem_ren=1:
  - Write mem_rdata and fetch_pc at the write pointer.
  - Advance the write pointer.
  - fetch_pc <= fetch_pc + 1 (word addressing; 32'hFFFFFFFF wraps to 0).
- Pop, when deq_valid && deq_ready && !redirect: advance the read pointer.
- count:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged when push and pop happen in the same cycle.
- Full (count == DEPTH):
  - No fetch; fetch_pc holds.
  - A pop in this cycle frees an entry, and fetch resumes on the next cycle (no same-cycle bypass; mem_ren does not depend on deq_ready).
- Empty: deq_valid=0. deq_ready is ignored. Fetch continues.
- Redirect (highest priority):
  - On the edge: both pointers <= 0, count <= 0, fetch_pc <= redirect_pc.
  - No push and no pop in that cycle. The head word shown in that cycle is discarded even if deq_ready=1.
- Simultaneous redirect with full or empty: the flush outcome is identical in both cases.
- Reset (asynchronous, at any time, including mid-fill):
  - fetch_pc <= RESET_PC.
  - Pointers and count <= 0.
  - The storage arrays need not be reset.
  - Outputs during reset: deq_valid=0, deq_instr=0, deq_pc=0, count=0, mem_raddr=RESET_PC, mem_ren=1.

## Timing
- Fetch-to-dequeue latency:
  - A word fetched in cycle N is visible at the head in cycle N+1 when the queue was empty.
  - Otherwise it waits behind older entries.
- After rst deasserts, the first edge fetches RESET_PC, and deq_valid=1 in the following cycle.
- Redirect asserted in cycle N:
  - Cycle N+1: fetches redirect_pc.
  - Cycle N+2: deq_valid=1 with deq_pc=redirect_pc.
- Steady state with deq_ready held at 1: one instruction per cycle, and count stays at 1.
- Stall: deq_ready=0 for k cycles fills the queue to min(count+k, DEPTH). Once full, fetch_pc holds.
- All outputs are registered state or combinational functions of state, except mem_ren, which also depends on redirect. There is no combinational path from deq_ready to any output.

## Test plan
- Reset release, RESET_PC=0, memory[i]=i+100, deq_ready=1 -> deq_pc sequence 0,1,2,… with deq_instr 100,101,… one per cycle from cycle 1; count=1 steady.
- deq_ready=0 for 6 cycles with DEPTH=4 -> count saturates at 4, mem_ren=0, mem_raddr frozen at 4. Release -> words 0..3 dequeued in order, then 4,5 follow with no gap and no duplicates.
- Redirect to 0x40 while count=3 -> next cycle count=0, deq_valid=0, mem_raddr=0x40. Two cycles after redirect, deq_pc=0x40. Old entries are never dequeued.
- Redirect and deq_ready both high while full -> the head is not consumed, the flush completes, and count=0.
- Redirect to 0xFFFFFFFE -> deq_pc sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0. Write-pointer wraparound is exercised over more than 3·DEPTH pushes with data integrity preserved.
- rst asserted asynchronously mid-fill (count=2, between edges) -> outputs take reset values immediately. After release, fetch restarts at RESET_PC.
